// File: rtl/wimpfi_pkg.sv
// Shared constants and state encoding for the WimpFi transmit framer.
package wimpfi_pkg;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD0;
    localparam logic [7:0] EOT_BYTE      = 8'h04;
    localparam logic [7:0] TYPE_DATA     = 8'h30;
    localparam logic [7:0] TYPE_DATA_CRC = 8'h32;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DEFER,
        ST_PREAMBLE,
        ST_SFD,
        ST_DEST,
        ST_SRC,
        ST_TYPE,
        ST_PAYLOAD,
        ST_CRC
    } frame_state_t;

endpackage

// File: rtl/wimpfi_frame_builder_crc8.sv
// Combinational CRC-8 (poly 0x07, MSB-first) advanced by one byte.
// Present only when WIMPFI_FRAME_CRC_EN is defined.
`ifdef WIMPFI_FRAME_CRC_EN
module crc8_byte (
    input  logic [7:0] crc_in,
    input  logic [7:0] data,
    output logic [7:0] crc_out
);

    logic [7:0] c;

    always_comb begin
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        crc_out = c;
    end

endmodule
`endif

// File: rtl/wimpfi_frame_builder.sv
// WimpFi transmit framer: buffers a UART upload, defers on carrier, streams the frame.
// Define WIMPFI_FRAME_CRC_EN to append a CRC-8 trailer and use TYPE 0x32.
module wimpfi_frame_builder
    import wimpfi_pkg::*;
#(
    parameter int MAX_PAYLOAD    = 255,
    parameter int PREAMBLE_BYTES = 2,
    parameter int IFS_CYCLES     = 4800
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] uart_data,
    input  logic       uart_valid,
    input  logic [7:0] src_addr,
    input  logic       cardet,
    input  logic       xmit_rdy,
    output logic [7:0] xmit_data,
    output logic       xmit_valid,
    output logic       busy,
    output logic [7:0] drop_cnt
);

    localparam int AW    = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int CNT_W = $clog2(IFS_CYCLES + 1);

    frame_state_t     state, state_next;
    logic [7:0]       data_next;
    logic             valid_next;
    logic [7:0]       wr_ptr, wr_ptr_next;
    logic [7:0]       rd_ptr, rd_ptr_next;
    logic [CNT_W-1:0] idle_cnt, idle_next;
    logic [7:0]       pre_cnt, pre_next;
    logic             wr_en, dest_en, xfer;
    logic [7:0]       dest, rd_data;
    logic [7:0]       mem [0:MAX_PAYLOAD-1];
    logic [7:0]       crc_upd;

`ifdef WIMPFI_FRAME_CRC_EN
    localparam bit         CRC_ON    = 1'b1;
    localparam logic [7:0] TYPE_CODE = TYPE_DATA_CRC;
    logic [7:0] crc;

    crc8_byte u_crc8 (
        .crc_in (crc),
        .data   (xmit_data),
        .crc_out(crc_upd)
    );

    // CRC covers the bytes from DEST through the last payload byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= 8'h00;
        end else if (state == ST_DEFER && state_next == ST_PREAMBLE) begin
            crc <= 8'h00;
        end else if (xfer && (state inside {ST_DEST, ST_SRC, ST_TYPE, ST_PAYLOAD})) begin
            crc <= crc_upd;
        end
    end
`else
    localparam bit         CRC_ON    = 1'b0;
    localparam logic [7:0] TYPE_CODE = TYPE_DATA;
    assign crc_upd = 8'h00;
`endif

    assign xfer = xmit_valid && xmit_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            xmit_data  <= 8'h00;
            xmit_valid <= 1'b0;
            busy       <= 1'b0;
            drop_cnt   <= 8'h00;
            wr_ptr     <= 8'h00;
            rd_ptr     <= 8'h00;
            idle_cnt   <= '0;
            pre_cnt    <= 8'h00;
        end else begin
            state      <= state_next;
            xmit_data  <= data_next;
            xmit_valid <= valid_next;
            busy       <= !(state_next inside {ST_IDLE, ST_LOAD});
            wr_ptr     <= wr_ptr_next;
            rd_ptr     <= rd_ptr_next;
            idle_cnt   <= idle_next;
            pre_cnt    <= pre_next;
            if (uart_valid && busy && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Payload RAM: read address follows the next pointer so the byte after
    // the current one is already on rd_data when the handshake happens.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= uart_data;
        end
        if (rd_ptr_next < 8'(MAX_PAYLOAD)) begin
            rd_data <= mem[rd_ptr_next[AW-1:0]];
        end
        if (dest_en) begin
            dest <= uart_data;
        end
    end

    always_comb begin
        state_next  = state;
        data_next   = xmit_data;
        valid_next  = xmit_valid;
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        idle_next   = idle_cnt;
        pre_next    = pre_cnt;
        wr_en       = 1'b0;
        dest_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (uart_valid && uart_data != EOT_BYTE) begin
                    dest_en    = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (uart_valid) begin
                    if (uart_data == EOT_BYTE) begin
                        state_next = ST_DEFER;
                    end else begin
                        wr_en       = 1'b1;
                        wr_ptr_next = wr_ptr + 8'd1;
                        if (wr_ptr + 8'd1 == 8'(MAX_PAYLOAD)) begin
                            state_next = ST_DEFER;
                        end
                    end
                end
            end
            ST_DEFER: begin
                if (cardet) begin
                    idle_next = '0;
                end else if (idle_cnt == CNT_W'(IFS_CYCLES - 1)) begin
                    idle_next  = '0;
                    pre_next   = 8'h00;
                    state_next = ST_PREAMBLE;
                    data_next  = PREAMBLE_BYTE;
                    valid_next = 1'b1;
                end else begin
                    idle_next = idle_cnt + CNT_W'(1);
                end
            end
            ST_PREAMBLE: begin
                if (xfer) begin
                    if (pre_cnt == 8'(PREAMBLE_BYTES - 1)) begin
                        state_next = ST_SFD;
                        data_next  = SFD_BYTE;
                    end else begin
                        pre_next = pre_cnt + 8'd1;
                    end
                end
            end
            ST_SFD: begin
                if (xfer) begin
                    state_next = ST_DEST;
                    data_next  = dest;
                end
            end
            ST_DEST: begin
                if (xfer) begin
                    state_next = ST_SRC;
                    data_next  = src_addr;
                end
            end
            ST_SRC: begin
                if (xfer) begin
                    state_next = ST_TYPE;
                    data_next  = TYPE_CODE;
                end
            end
            ST_TYPE, ST_PAYLOAD: begin
                // rd_ptr indexes the next payload byte; equal to wr_ptr means done.
                if (xfer) begin
                    if (rd_ptr == wr_ptr) begin
                        if (CRC_ON) begin
                            state_next = ST_CRC;
                            data_next  = crc_upd;
                        end else begin
                            state_next  = ST_IDLE;
                            valid_next  = 1'b0;
                            wr_ptr_next = 8'h00;
                            rd_ptr_next = 8'h00;
                        end
                    end else begin
                        state_next  = ST_PAYLOAD;
                        data_next   = rd_data;
                        rd_ptr_next = rd_ptr + 8'd1;
                    end
                end
            end
            ST_CRC: begin
                if (xfer) begin
                    state_next  = ST_IDLE;
                    valid_next  = 1'b0;
                    wr_ptr_next = 8'h00;
                    rd_ptr_next = 8'h00;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_wimpfi_frame_builder.sv
// Randomized scoreboard bench for wimpfi_frame_builder; the model builds whole frames.
`timescale 1ns/1ps
module tb_wimpfi_frame_builder;

    localparam int MAXP = 255;
    localparam int PRE  = 2;
    localparam int IFS  = 16;
`ifdef WIMPFI_FRAME_CRC_EN
    localparam bit         CRC_ON = 1'b1;
    localparam logic [7:0] TYPEB  = 8'h32;
`else
    localparam bit         CRC_ON = 1'b0;
    localparam logic [7:0] TYPEB  = 8'h30;
`endif

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] uart_data = 8'h00;
    logic       uart_valid = 1'b0;
    logic [7:0] src_addr = 8'h22;
    logic       cardet = 1'b0;
    logic       xmit_rdy = 1'b1;
    logic [7:0] xmit_data;
    logic       xmit_valid;
    logic       busy;
    logic [7:0] drop_cnt;

    int         checks = 0;
    int         failures = 0;
    int         xfer_cnt = 0;
    int         exp_drops = 0;
    bit         rdy_rand = 1'b0;
    logic [7:0] exp_q[$];
    bit         stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;

    wimpfi_frame_builder #(
        .MAX_PAYLOAD   (MAXP),
        .PREAMBLE_BYTES(PRE),
        .IFS_CYCLES    (IFS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_data (uart_data),
        .uart_valid(uart_valid),
        .src_addr  (src_addr),
        .cardet    (cardet),
        .xmit_rdy  (xmit_rdy),
        .xmit_data (xmit_data),
        .xmit_valid(xmit_valid),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        xmit_rdy = rdy_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endfunction

    // Bit-serial CRC-8, poly x^8+x^2+x+1, MSB first, init 0.
    function automatic logic [7:0] crc_bits(input logic [7:0] crc, input logic [7:0] b);
        logic fb;
        for (int i = 7; i >= 0; i--) begin
            fb  = crc[7] ^ b[i];
            crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return crc;
    endfunction

    task automatic push_frame(input logic [7:0] d, input byte_q_t pl);
        logic [7:0] crc;
        for (int i = 0; i < PRE; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD0);
        exp_q.push_back(d);
        exp_q.push_back(src_addr);
        exp_q.push_back(TYPEB);
        crc = crc_bits(crc_bits(crc_bits(8'h00, d), src_addr), TYPEB);
        foreach (pl[i]) begin
            exp_q.push_back(pl[i]);
            crc = crc_bits(crc, pl[i]);
        end
        if (CRC_ON) exp_q.push_back(crc);
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_data  = b;
        uart_valid = 1'b1;
        @(posedge clk);
        #1;
        uart_valid = 1'b0;
    endtask

    task automatic upload(input logic [7:0] d, input byte_q_t pl, input bit eot);
        send_byte(d);
        foreach (pl[i]) send_byte(pl[i]);
        if (eot) send_byte(8'h04);
    endtask

    function automatic logic [7:0] rand_nonEot();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        return (b == 8'h04) ? 8'h05 : b;
    endfunction

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: %0d bytes still expected", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
        check({name, "_end_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_end_valid"}, {31'd0, xmit_valid}, 32'd0);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_hold", {23'd0, xmit_valid, xmit_data}, {23'd0, 1'b1, stall_data});
            end
            if (xmit_valid && xmit_rdy) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte: got 0x%0h expected none", xmit_data);
                end else begin
                    check("frame_byte", {24'd0, xmit_data}, {24'd0, exp_q.pop_front()});
                end
            end
            stall_prev = xmit_valid && !xmit_rdy;
            stall_data = xmit_data;
        end
    end

    initial begin
        byte_q_t pl;
        int      n;
        int      base;
        bit      quiet;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, xmit_valid}, 32'd0);
        check("rst_data", {24'd0, xmit_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_drop", {24'd0, drop_cnt}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic "HI" frame.
        pl = '{8'h48, 8'h49};
        push_frame(8'h41, pl);
        upload(8'h41, pl, 1'b1);
        wait_done("basic");

        // Zero-length payload, then a lone EOT that must be ignored.
        pl = {};
        push_frame(8'h41, pl);
        upload(8'h41, pl, 1'b1);
        wait_done("zero_payload");
        send_byte(8'h04);
        quiet = 1'b1;
        repeat (3 * IFS) begin
            @(posedge clk);
            #1;
            if (xmit_valid || busy) quiet = 1'b0;
        end
        check("lone_eot_quiet", {31'd0, quiet}, 32'd1);
        check("lone_eot_drop", {24'd0, drop_cnt}, exp_drops);

        // Carrier busy defers; a short gap followed by a glitch restarts the count.
        cardet = 1'b1;
        pl = '{rand_nonEot(), rand_nonEot(), rand_nonEot()};
        push_frame(8'h41, pl);
        upload(8'h41, pl, 1'b1);
        quiet = 1'b1;
        repeat (3 * IFS) begin
            @(posedge clk);
            #1;
            if (xmit_valid) quiet = 1'b0;
        end
        check("cardet_hold", {31'd0, quiet}, 32'd1);
        cardet = 1'b0;
        repeat (IFS - 1) begin
            @(posedge clk);
            #1;
        end
        cardet = 1'b1;
        @(posedge clk);
        #1;
        cardet = 1'b0;
        n = 0;
        while (!xmit_valid && n < 4 * IFS) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ifs_gap", n, IFS);
        wait_done("cardet");

        // Random frames under 30% ready duty.
        rdy_rand = 1'b1;
        for (int f = 0; f < 4; f++) begin
            logic [7:0] d;
            pl = {};
            d = rand_nonEot();
            src_addr = 8'($urandom_range(0, 255));
            for (int i = 0; i < int'($urandom_range(0, 20)); i++) pl.push_back(rand_nonEot());
            push_frame(d, pl);
            upload(d, pl, 1'b1);
            wait_done("rand_frame");
        end
        rdy_rand = 1'b0;
        src_addr = 8'h22;

        // Full buffer auto-terminates; two bytes during transmit are dropped.
        pl = {};
        for (int i = 0; i < MAXP; i++) pl.push_back(rand_nonEot());
        push_frame(8'h41, pl);
        base = xfer_cnt;
        upload(8'h41, pl, 1'b0);
        n = 0;
        while (!xmit_valid && n < 4 * IFS) begin
            @(posedge clk);
            #1;
            n++;
        end
        send_byte(8'h11);
        send_byte(8'h04);
        exp_drops += 2;
        wait_done("max_frame");
        check("max_frame_len", xfer_cnt - base, PRE + 4 + MAXP + (CRC_ON ? 1 : 0));
        check("drop_count", {24'd0, drop_cnt}, exp_drops);

        // Reset in the middle of the payload.
        pl = {};
        for (int i = 0; i < 10; i++) pl.push_back(rand_nonEot());
        push_frame(8'h41, pl);
        base = xfer_cnt;
        upload(8'h41, pl, 1'b1);
        n = 0;
        while (xfer_cnt < base + PRE + 4 + 3 && n < 4 * IFS + 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mid_payload_reached", {31'd0, xfer_cnt >= base + PRE + 4 + 3}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_valid", {31'd0, xmit_valid}, 32'd0);
        check("midrst_data", {24'd0, xmit_data}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_drop", {24'd0, drop_cnt}, 32'd0);
        exp_q.delete();
        exp_drops = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Recovery frame after reset.
        pl = '{8'h48, 8'h49};
        push_frame(8'h41, pl);
        upload(8'h41, pl, 1'b1);
        wait_done("recovery");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
